usb_rx_ctrl: RTL and testbench

Receive-side sequencer for the USB 1.0 receiver. Consumes the NRZI-decoded bit stream and end-of-packet indication produced by `decoder`, qualified by a one-cycle bit strobe from the bit-timing logic. Handles SYNC detection, bit-unstuffing, PID validation, byte assembly, and EOP/error recovery. Presents assembled bytes and packet status to the downstream receive buffer.

---
 rtl/usb_rx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_ctrl.sv
// USB 1.0 receive sequencer: SYNC detect, bit-unstuffing, PID check, byte assembly, EOP/error recovery.
// Optional: define USB_STUFF_CHECK_EN to flag a 1 in the stuff-bit position as a receive error.
module usb_rx_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_valid,
  input  logic       d_orig,
  input  logic       end_packet,
  output logic       rx_active,
  output logic [3:0] rx_pid,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_done,
  output logic       rx_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_EOP,
    S_ERR
  } state_t;

  state_t     state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [2:0] ones, ones_n;
  logic       se0_seen, se0_seen_n;
  logic       active_n, valid_n, done_n, error_n;
  logic [3:0] pid_n;
  logic [7:0] data_n;
  logic [7:0] byte_next;
  logic       stuff_bit;
  logic       byte_end;

  assign byte_next = {d_orig, shreg[7:1]};
  assign stuff_bit = (ones == 3'd6);
  assign byte_end  = (bit_cnt == 3'd7);

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    ones_n     = ones;
    se0_seen_n = se0_seen;
    active_n   = rx_active;
    pid_n      = rx_pid;
    data_n     = rx_data;
    error_n    = rx_error;
    valid_n    = 1'b0;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bit_valid && !d_orig) begin
          state_n   = S_SYNC;
          error_n   = 1'b0;
          active_n  = 1'b1;
          shreg_n   = byte_next;
          bit_cnt_n = 3'd1;
          ones_n    = '0;
        end
      end

      S_SYNC, S_PID, S_DATA: begin
        // SE0 wins over a coincident bit strobe; that bit never reaches the shifter.
        if (end_packet) begin
          if (state == S_DATA && bit_cnt == 3'd0) begin
            state_n = S_EOP;
          end else begin
            state_n    = S_ERR;
            error_n    = 1'b1;
            se0_seen_n = 1'b1;
          end
        end else if (bit_valid) begin
          if (stuff_bit) begin
            ones_n = '0;
`ifdef USB_STUFF_CHECK_EN
            if (d_orig) begin
              state_n    = S_ERR;
              error_n    = 1'b1;
              se0_seen_n = 1'b0;
            end
`endif
          end else begin
            shreg_n   = byte_next;
            bit_cnt_n = bit_cnt + 3'd1;
            ones_n    = d_orig ? ones + 3'd1 : '0;
            if (byte_end) begin
              case (state)
                S_SYNC: begin
                  if (byte_next == 8'h80) begin
                    state_n = S_PID;
                  end else begin
                    state_n    = S_ERR;
                    error_n    = 1'b1;
                    se0_seen_n = 1'b0;
                  end
                end
                S_PID: begin
                  if (byte_next[7:4] == ~byte_next[3:0]) begin
                    pid_n   = byte_next[3:0];
                    state_n = S_DATA;
                  end else begin
                    state_n    = S_ERR;
                    error_n    = 1'b1;
                    se0_seen_n = 1'b0;
                  end
                end
                S_DATA: begin
                  data_n  = byte_next;
                  valid_n = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      end

      S_EOP: begin
        if (!end_packet) begin
          done_n   = 1'b1;
          active_n = 1'b0;
          state_n  = S_IDLE;
        end
      end

      S_ERR: begin
        error_n = 1'b1;
        if (end_packet) begin
          se0_seen_n = 1'b1;
        end else if (se0_seen) begin
          active_n = 1'b0;
          state_n  = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= S_IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      ones          <= '0;
      se0_seen      <= 1'b0;
      rx_active     <= 1'b0;
      rx_pid        <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_done       <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      state         <= state_n;
      shreg         <= shreg_n;
      bit_cnt       <= bit_cnt_n;
      ones          <= ones_n;
      se0_seen      <= se0_seen_n;
      rx_active     <= active_n;
      rx_pid        <= pid_n;
      rx_data       <= data_n;
      rx_data_valid <= valid_n;
      rx_done       <= done_n;
      rx_error      <= error_n;
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed self-checking bench for usb_rx_ctrl; stuff-violation expectations follow USB_STUFF_CHECK_EN.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       bit_valid;
  logic       d_orig;
  logic       end_packet;
  logic       rx_active;
  logic [3:0] rx_pid;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_done;
  logic       rx_error;

  int vectors = 0;
  int miscompares = 0;
  int vcnt = 0;
  int dcnt = 0;
  int vbase = 0;
  int dbase = 0;
  logic [7:0] last_byte = '0;

  always #5 clk = ~clk;

  usb_rx_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .bit_valid    (bit_valid),
    .d_orig       (d_orig),
    .end_packet   (end_packet),
    .rx_active    (rx_active),
    .rx_pid       (rx_pid),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_done      (rx_done),
    .rx_error     (rx_error)
  );

  // Pulse counters observed mid-cycle
  always @(negedge clk) begin
    if (rx_data_valid) begin
      vcnt++;
      last_byte = rx_data;
    end
    if (rx_done) dcnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    d_orig    = b;
    @(negedge clk);
    bit_valid = 1'b0;
    d_orig    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic se0(input int unsigned n);
    end_packet = 1'b1;
    repeat (n) @(negedge clk);
    end_packet = 1'b0;
  endtask

  initial begin
    n_rst      = 1'b0;
    bit_valid  = 1'b0;
    d_orig     = 1'b0;
    end_packet = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_active", rx_active, 0);
    chk("rst_pid", rx_pid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_data_valid, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_error", rx_error, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Clean packet, back-to-back bits
    vbase = vcnt; dbase = dcnt;
    send_byte(8'h80, 0);
    chk("t1_active", rx_active, 1);
    chk("t1_err_sync", rx_error, 0);
    send_byte(8'hC3, 0);
    chk("t1_pid", rx_pid, 4'h3);
    send_byte(8'h12, 0);
    chk("t1_valid0", rx_data_valid, 1);
    chk("t1_data0", rx_data, 8'h12);
    send_byte(8'h34, 0);
    chk("t1_valid1", rx_data_valid, 1);
    chk("t1_data1", rx_data, 8'h34);
    se0(4);
    chk("t1_active_eop", rx_active, 1);
    @(negedge clk);
    chk("t1_done", rx_done, 1);
    chk("t1_active_end", rx_active, 0);
    @(negedge clk);
    chk("t1_done_pulse", rx_done, 0);
    #1;
    chk("t1_nvalid", vcnt - vbase, 2);
    chk("t1_ndone", dcnt - dbase, 1);
    chk("t1_error", rx_error, 0);

    // Bad PID
    vbase = vcnt; dbase = dcnt;
    send_byte(8'h80, 0);
    send_byte(8'h33, 0);
    chk("t2_error", rx_error, 1);
    chk("t2_active", rx_active, 1);
    chk("t2_pid_held", rx_pid, 4'h3);
    se0(4);
    @(negedge clk);
    chk("t2_active_end", rx_active, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("t2_nvalid", vcnt - vbase, 0);
    chk("t2_ndone", dcnt - dbase, 0);
    chk("t2_error_sticky", rx_error, 1);

    // Unstuffing: 0x C3 leaves two trailing ones, so the stuff bit follows four data ones
    vbase = vcnt; dbase = dcnt;
    send_bit(1'b0);
    chk("t3_err_clear", rx_error, 0);
    chk("t3_active", rx_active, 1);
    repeat (6) send_bit(1'b0);
    send_bit(1'b1);
    send_byte(8'hC3, 0);
    repeat (4) send_bit(1'b1);
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    chk("t3_valid_ff", rx_data_valid, 1);
    chk("t3_data_ff", rx_data, 8'hFF);
    send_byte(8'h00, 0);
    chk("t3_valid_00", rx_data_valid, 1);
    chk("t3_data_00", rx_data, 8'h00);
    se0(4);
    @(negedge clk);
    chk("t3_done", rx_done, 1);
    chk("t3_error", rx_error, 0);
    #1;
    chk("t3_nvalid", vcnt - vbase, 2);
    chk("t3_ndone", dcnt - dbase, 1);

    // Stuff bit of value 1
    vbase = vcnt; dbase = dcnt;
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    repeat (4) send_bit(1'b1);
    send_bit(1'b1);
`ifdef USB_STUFF_CHECK_EN
    chk("t4_error", rx_error, 1);
    chk("t4_active", rx_active, 1);
    se0(4);
    @(negedge clk);
    chk("t4_active_end", rx_active, 0);
    #1;
    chk("t4_nvalid", vcnt - vbase, 0);
    chk("t4_ndone", dcnt - dbase, 0);
`else
    chk("t4_error", rx_error, 0);
    repeat (4) send_bit(1'b1);
    chk("t4_valid_ff", rx_data_valid, 1);
    chk("t4_data_ff", rx_data, 8'hFF);
    send_byte(8'h00, 0);
    chk("t4_data_00", rx_data, 8'h00);
    se0(4);
    @(negedge clk);
    chk("t4_done", rx_done, 1);
    chk("t4_error_end", rx_error, 0);
    #1;
    chk("t4_nvalid", vcnt - vbase, 2);
    chk("t4_ndone", dcnt - dbase, 1);
`endif

    // EOP after five data bits
    vbase = vcnt; dbase = dcnt;
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    end_packet = 1'b1;
    @(negedge clk);
    chk("t5_error", rx_error, 1);
    chk("t5_active", rx_active, 1);
    repeat (3) @(negedge clk);
    end_packet = 1'b0;
    @(negedge clk);
    chk("t5_active_end", rx_active, 0);
    #1;
    chk("t5_nvalid", vcnt - vbase, 0);
    chk("t5_ndone", dcnt - dbase, 0);

    // Zero-length packet; SE0 coincides with a bit strobe that must be dropped
    vbase = vcnt; dbase = dcnt;
    send_byte(8'h80, 0);
    send_byte(8'h5A, 0);
    chk("t6_pid", rx_pid, 4'hA);
    end_packet = 1'b1;
    bit_valid  = 1'b1;
    d_orig     = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    d_orig    = 1'b0;
    @(negedge clk);
    end_packet = 1'b0;
    @(negedge clk);
    chk("t6_done", rx_done, 1);
    chk("t6_error", rx_error, 0);
    chk("t6_active", rx_active, 0);
    #1;
    chk("t6_nvalid", vcnt - vbase, 0);
    chk("t6_ndone", dcnt - dbase, 1);

    // Asynchronous reset during DATA, then a spaced-out clean packet
    dbase = dcnt;
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t7_rst_active", rx_active, 0);
    chk("t7_rst_pid", rx_pid, 0);
    chk("t7_rst_data", rx_data, 0);
    chk("t7_rst_error", rx_error, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t7_ndone_abort", dcnt - dbase, 0);
    vbase = vcnt; dbase = dcnt;
    @(negedge clk);
    send_byte(8'h80, 1);
    send_byte(8'h5A, 1);
    send_byte(8'h34, 1);
    chk("t7_data", rx_data, 8'h34);
    se0(4);
    @(negedge clk);
    chk("t7_done", rx_done, 1);
    chk("t7_pid", rx_pid, 4'hA);
    chk("t7_error", rx_error, 0);
    #1;
    chk("t7_nvalid", vcnt - vbase, 1);
    chk("t7_last_byte", last_byte, 8'h34);
    chk("t7_ndone", dcnt - dbase, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
